stop_watch_ctrl: RTL
====================

Name: stop_watch_ctrl

Overview:
Run/pause/clear/lap sequencer for the 4-digit BCD stopwatch counter. It converts debounced single-cycle button pulses into the counter's increment strobe and clear, derives the count tick from the system clock with a prescaler, and selects live or frozen (lap) digits for the display path. It sits between the button debouncers and the BCD counter / 7-segment display mux.

Parameters:
DIV, 100000, clk cycles per count tick (must be >= 2)
DIV_W, 17, prescaler width; must satisfy 2**DIV_W >= DIV

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_stop  input  1  single-cycle pulse, toggles run/pause
clr_btn  input  1  single-cycle pulse, clear request
lap_btn  input  1  single-cycle pulse, lap freeze/release
bcd_in  input  16  live counter digits {d3,d2,d1,d0}, registered in counter
cnt_en  output  1  increment strobe to counter (one clk wide)
cnt_clr  output  1  clear strobe to counter (one clk wide)
disp  output  16  digits for display: live bcd_in or lap snapshot
running  output  1  high in RUN
lap_active  output  1  high while disp shows the lap snapshot
sat  output  1  saturation flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE, prescaler 0, lap_reg 16'h0000, lap_active 0, sat 0; cnt_en 0, cnt_clr 0, running 0.
- States: IDLE (stopped at zero), RUN, PAUSE.
- IDLE: start_stop -> RUN. clr_btn -> cnt_clr pulse, stay IDLE. lap_btn ignored.
- RUN: start_stop -> PAUSE. clr_btn ignored. lap_btn toggles lap_active; on 0->1, lap_reg <= bcd_in in the same edge.
- PAUSE: start_stop -> RUN, prescaler resumes from held value. clr_btn -> cnt_clr pulse, prescaler <= 0, lap_active <= 0, sat <= 0, state IDLE. lap_btn with lap_active=1 releases it (0); with lap_active=0 it is ignored.
- Simultaneous pulses: clr_btn beats start_stop in IDLE/PAUSE. start_stop beats clr_btn in RUN (clr ignored). lap_btn is processed in the same cycle as start_stop (RUN->PAUSE and lap toggle both take effect).
- Prescaler: increments only in RUN. Wraps DIV-1 -> 0. Holds in PAUSE. Zero in IDLE.
- cnt_en = (state==RUN) && (prescaler==DIV-1), decoded from registers, so one pulse per DIV RUN cycles.
- Latency: start_stop sampled at edge k gives RUN from edge k. The first cnt_en is high in the DIV-th RUN cycle. The counter increments at the next edge.
- cnt_clr is registered: high exactly one cycle after the edge that samples clr_btn.
- disp = lap_active ? lap_reg : bcd_in (combinational mux). running = (state==RUN).
- cnt_en and cnt_clr are never high in the same cycle.
- Wrap: without the optional feature, cnt_en keeps pulsing at 9999 and the counter wraps to 0000. The controller does not intervene.

Optional Feature:
Macro STOP_WATCH_SAT_EN.
- Defined: in RUN, when bcd_in==16'h9999 and cnt_en would fire, cnt_en is suppressed, state -> PAUSE, sat <= 1. sat stays high until a clear. While sat=1, start_stop in PAUSE is ignored.
- Undefined: sat is tied to 0; counter wraps 9999 -> 0000.

Decomposition:
- Package stop_watch_pkg holds:
  - state typedef (IDLE, RUN, PAUSE), 2-bit encoding
  - BCD_W = 16
  - DIV_DEFAULT = 100000
  - BCD_MAX = 16'h9999
- Sub-module stop_watch_prescaler (ports clk, rst_n, en, clr, tick; parameters DIV, DIV_W) holds the modulo-DIV counter and tick decode. FSM, lap register and display mux stay in stop_watch_ctrl.

Test Plan:
1. DIV=4: reset, start_stop at cycle 2, hold RUN 16 cycles -> cnt_en pulses at cycles 6, 10, 14, 18; running=1; bcd_in from a counter model reaches 0004.
2. DIV=4: RUN 2 cycles, start_stop (PAUSE) for 10 cycles, start_stop again -> no cnt_en during PAUSE; the first pulse after resume arrives after the 2 remaining prescaler cycles.
3. PAUSE with count 0042, clr_btn and start_stop in the same cycle -> cnt_clr high one cycle, state IDLE, running=0, prescaler 0, disp 0000.
4. RUN, lap_btn at count 0123, counter continues to 0130 -> disp stays 0123, lap_active=1; a second lap_btn -> disp tracks bcd_in (0130+).
5. RUN, clr_btn pulse -> no cnt_clr, counting continues unchanged.
6. DIV=4, bcd_in forced 9999 in RUN:
   - with STOP_WATCH_SAT_EN: cnt_en suppressed, PAUSE, sat=1, start_stop ignored, clr_btn clears sat.
   - without it: cnt_en fires, counter wraps to 0000, sat=0.

Source files
------------

// File: rtl/stop_watch_pkg.sv
//------------------------------------------------------------------------------
// stop_watch_pkg : shared types and constants for the stopwatch controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package stop_watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int               BCD_W       = 16;
    localparam int               DIV_DEFAULT = 100000;
    localparam logic [BCD_W-1:0] BCD_MAX     = 16'h9999;

endpackage

`default_nettype wire

// File: rtl/stop_watch_prescaler.sv
//------------------------------------------------------------------------------
// stop_watch_prescaler : modulo-DIV cycle counter with terminal-count decode
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stop_watch_prescaler #(
    parameter int DIV   = 100000,
    parameter int DIV_W = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] c_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    // Clear wins over enable; the count holds whenever en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/stop_watch_ctrl.sv
//------------------------------------------------------------------------------
// stop_watch_ctrl : run/pause/clear/lap sequencer for a 4-digit BCD stopwatch
// Optional macro STOP_WATCH_SAT_EN: pause and flag saturation at 9999.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stop_watch_ctrl
    import stop_watch_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int DIV_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_stop,
    input  logic             clr_btn,
    input  logic             lap_btn,
    input  logic [BCD_W-1:0] bcd_in,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [BCD_W-1:0] disp,
    output logic             running,
    output logic             lap_active,
    output logic             sat
);

    state_t           r_state;
    logic             r_lap_active;
    logic [BCD_W-1:0] r_lap_reg;
    logic             r_sat;
    logic             r_cnt_clr;

    logic w_run;
    logic w_tick;
    logic w_sat_hit;
    logic w_presc_clr;

    assign w_run       = (r_state == ST_RUN);
    assign w_presc_clr = (r_state == ST_PAUSE) && clr_btn;

    stop_watch_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_run),
        .clr   (w_presc_clr),
        .tick  (w_tick)
    );

`ifdef STOP_WATCH_SAT_EN
    assign w_sat_hit = w_run && w_tick && (bcd_in == BCD_MAX);
`else
    assign w_sat_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_lap_active <= 1'b0;
            r_lap_reg    <= '0;
            r_sat        <= 1'b0;
            r_cnt_clr    <= 1'b0;
        end else begin
            r_cnt_clr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clr_btn) begin
                        r_cnt_clr <= 1'b1;
                    end else if (start_stop) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_stop || w_sat_hit) begin
                        r_state <= ST_PAUSE;
                    end
                    if (w_sat_hit) begin
                        r_sat <= 1'b1;
                    end
                    // Snapshot is taken only on the release-to-freeze edge.
                    if (lap_btn) begin
                        r_lap_active <= !r_lap_active;
                        if (!r_lap_active) begin
                            r_lap_reg <= bcd_in;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clr_btn) begin
                        r_cnt_clr    <= 1'b1;
                        r_lap_active <= 1'b0;
                        r_sat        <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        if (start_stop && !r_sat) begin
                            r_state <= ST_RUN;
                        end
                        if (lap_btn && r_lap_active) begin
                            r_lap_active <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cnt_en     = w_run && w_tick && !w_sat_hit;
    assign cnt_clr    = r_cnt_clr;
    assign disp       = r_lap_active ? r_lap_reg : bcd_in;
    assign running    = w_run;
    assign lap_active = r_lap_active;
    assign sat        = r_sat;

endmodule

`default_nettype wire
